// File: rtl/sprite_reg_master_if.sv
// Sprite register bus bundle: valid/ready write source plus the reg_addr/data/we responder bus.
interface sprite_reg_master_if;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    input  wr_data, wr_valid, reg_rdata,
    output wr_ready, reg_addr, reg_wdata, reg_we
  );

  modport slave (
    output wr_data, wr_valid, reg_rdata,
    input  wr_ready, reg_addr, reg_wdata, reg_we
  );
endinterface

// File: rtl/sprite_reg_master.sv
// Frame-update bus initiator: lock, stream sprite regs, read status regs, unlock, publish snapshot.
module sprite_reg_master #(
  parameter int unsigned FIRST_ADDR  = 0,
  parameter int unsigned LAST_ADDR   = 21,
  parameter int unsigned LOCK_ADDR   = 22,
  parameter int unsigned STATUS_BASE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  sprite_reg_master_if.master    bus,
  output logic                   map_data,
  output logic [1:0]             player_rot,
  output logic [5:0]             frame_cnt,
  output logic                   pellet_data
);
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOCK, S_WRITE, S_READ, S_UNLOCK, S_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_j;
  logic          r_busy;
  logic          r_done;
  logic          r_wr_ready;
  logic          r_sh_map;
  logic [1:0]    r_sh_rot;
  logic [5:0]    r_sh_frame;
  logic          r_sh_pellet;
  logic          r_map;
  logic [1:0]    r_rot;
  logic [5:0]    r_frame;
  logic          r_pellet;

  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_we;
  logic          w_xfer;
  logic          w_unused_rdata;

  assign w_xfer         = r_wr_ready & bus.wr_valid;
  // Status fields only use the low bits of the read data.
  assign w_unused_rdata = ^bus.reg_rdata[DW-1:6];

  // Sequencer, shadow capture and snapshot publication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_j         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_sh_map    <= 1'b0;
      r_sh_rot    <= '0;
      r_sh_frame  <= '0;
      r_sh_pellet <= 1'b0;
      r_map       <= 1'b0;
      r_rot       <= '0;
      r_frame     <= '0;
      r_pellet    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOCK;
            r_busy  <= 1'b1;
          end
        end
        S_LOCK: begin
          r_state    <= S_WRITE;
          r_wr_ready <= 1'b1;
          r_idx      <= AW'(FIRST_ADDR);
        end
        S_WRITE: begin
          if (w_xfer) begin
            if (r_idx == AW'(LAST_ADDR)) begin
              r_state    <= S_READ;
              r_wr_ready <= 1'b0;
              r_j        <= '0;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
        S_READ: begin
          case (r_j)
            2'd0:    r_sh_map    <= bus.reg_rdata[0];
            2'd1:    r_sh_rot    <= bus.reg_rdata[1:0];
            2'd2:    r_sh_frame  <= bus.reg_rdata[5:0];
            default: r_sh_pellet <= bus.reg_rdata[0];
          endcase
          r_j <= r_j + 2'd1;
          if (r_j == 2'd3) r_state <= S_UNLOCK;
        end
        S_UNLOCK: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_map    <= r_sh_map;
          r_rot    <= r_sh_rot;
          r_frame  <= r_sh_frame;
          r_pellet <= r_sh_pellet;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus drive is a pure function of state, index and source data.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    case (r_state)
      S_LOCK: begin
        w_addr  = AW'(LOCK_ADDR);
        w_wdata = DW'(1);
        w_we    = 1'b1;
      end
      S_WRITE: begin
        w_addr  = r_idx;
        w_wdata = bus.wr_data;
        w_we    = bus.wr_valid;
      end
      S_READ: begin
        w_addr = AW'(STATUS_BASE) + AW'(r_j);
      end
      S_UNLOCK: begin
        w_addr = AW'(LOCK_ADDR);
        w_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.reg_addr  = w_addr;
  assign bus.reg_wdata = w_wdata;
  assign bus.reg_we    = w_we;
  assign bus.wr_ready  = r_wr_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign map_data      = r_map;
  assign player_rot    = r_rot;
  assign frame_cnt     = r_frame;
  assign pellet_data   = r_pellet;
endmodule

// File: tb/tb_sprite_reg_master.sv
// Scoreboard bench for sprite_reg_master with a behavioural sprite register file responder.
module tb_sprite_reg_master;
  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wr_valid = 1'b0;
  logic        busy, done, map_data, pellet_data;
  logic [1:0]  player_rot;
  logic [5:0]  frame_cnt;
  logic [15:0] rf [64];
  logic [15:0] status [4];

  int          n_total = 0;
  int          n_bad = 0;
  bus_t        exp_q[$];
  logic [9:0]  snap_q[$];
  logic [9:0]  exp_snap = '0;
  logic        snap_pending = 1'b0;

  sprite_reg_master_if bus_if();

  sprite_reg_master dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .bus         (bus_if),
    .map_data    (map_data),
    .player_rot  (player_rot),
    .frame_cnt   (frame_cnt),
    .pellet_data (pellet_data)
  );

  always #5 clk = ~clk;

  // Source: the value offered for a sprite reg is 0x0100 + its address.
  assign bus_if.wr_valid = wr_valid;
  assign bus_if.wr_data  = 16'h0100 + 16'(bus_if.reg_addr);

  // Responder register file; status regs 32..35 come from the bench.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) rf[i] <= '0;
    end else if (bus_if.reg_we) begin
      rf[bus_if.reg_addr] <= bus_if.reg_wdata;
    end
  end
  assign bus_if.reg_rdata = (bus_if.reg_addr >= 6'd32 && bus_if.reg_addr < 6'd36)
                            ? status[bus_if.reg_addr[1:0]] : rf[bus_if.reg_addr];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic bus_t mk(logic we, int addr, int data);
    bus_t t;
    t.we   = we;
    t.addr = 6'(addr);
    t.data = 16'(data);
    return t;
  endfunction

  function automatic logic [9:0] snap_now();
    return {map_data, player_rot, frame_cnt, pellet_data};
  endfunction

  // Monitor: compares each bus write/read and the snapshot around done.
  always @(negedge clk) begin
    if (!rst_n) begin
      snap_pending = 1'b0;
    end else begin
      if (bus_if.reg_we || bus_if.reg_addr >= 6'd32) begin
        if (exp_q.size() == 0) begin
          check("bus_unexpected", {9'd0, bus_if.reg_we, bus_if.reg_addr, bus_if.reg_wdata}, 32'hFFFF_FFFF);
        end else begin
          bus_t e;
          e = exp_q.pop_front();
          check("bus_we", 32'(bus_if.reg_we), 32'(e.we));
          check("bus_addr", 32'(bus_if.reg_addr), 32'(e.addr));
          if (e.we) check("bus_wdata", 32'(bus_if.reg_wdata), 32'(e.data));
        end
      end
      if (snap_pending) begin
        snap_pending = 1'b0;
        if (snap_q.size() == 0) begin
          check("snap_unexpected", 32'(snap_now()), 32'hFFFF_FFFF);
        end else begin
          exp_snap = snap_q.pop_front();
          check("snap_after_done", 32'(snap_now()), 32'(exp_snap));
        end
      end
      if (done) begin
        check("snap_before_done", 32'(snap_now()), 32'(exp_snap));
        snap_pending = 1'b1;
      end
    end
  end

  task automatic push_update(input logic [9:0] snap);
    exp_q.push_back(mk(1'b1, 22, 1));
    for (int a = 0; a <= 21; a++) exp_q.push_back(mk(1'b1, a, 16'h0100 + a));
    for (int j = 0; j < 4; j++) exp_q.push_back(mk(1'b0, 32 + j, 0));
    exp_q.push_back(mk(1'b1, 22, 0));
    snap_q.push_back(snap);
  endtask

  // One update: n counts cycles after the edge that samples start.
  task automatic run_update(input int stall_at, input int stall_len, input bit extra_starts,
                            output int done_n, output int busy_n);
    done_n = -1;
    busy_n = 0;
    wr_valid = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 200 && done_n < 0; n++) begin
      start = extra_starts && (n == 10 || n == 29);
      if (stall_len > 0 && n == 2 + stall_at) wr_valid = 1'b0;
      if (stall_len > 0 && n == 2 + stall_at + stall_len) wr_valid = 1'b1;
      @(negedge clk);
      if (stall_len > 0 && n >= 2 + stall_at && n < 2 + stall_at + stall_len) begin
        check("stall_we", 32'(bus_if.reg_we), 32'd0);
        check("stall_addr", 32'(bus_if.reg_addr), 32'(stall_at));
      end
      if (busy) busy_n++;
      if (done) done_n = n;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_n < 0) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
  endtask

  initial begin
    int dn, bn;
    status[0] = 16'hFFFF; status[1] = 16'h0006; status[2] = 16'h00AB; status[3] = 16'h0000;

    // Power-on reset
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {21'd0, done, bus_if.wr_ready, bus_if.reg_we, bus_if.reg_addr, snap_now()}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Scenario 1: asynchronous reset while idx 7 is on the bus
    exp_q.push_back(mk(1'b1, 22, 1));
    for (int a = 0; a <= 7; a++) exp_q.push_back(mk(1'b1, a, 16'h0100 + a));
    wr_valid = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_addr", 32'(bus_if.reg_addr), 32'd7);
    check("mid_we", 32'(bus_if.reg_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_bus", {9'd0, bus_if.wr_ready, bus_if.reg_we, bus_if.reg_addr, bus_if.reg_wdata}, 32'd0);
    check("async_snap", {21'd0, done, snap_now()}, 32'd0);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    snap_q.delete();
    exp_snap = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_rst", {29'd0, busy, bus_if.wr_ready, bus_if.reg_we}, 32'd0);
    end

    // Scenarios 2 and 3: full update, latency, status capture
    push_update({1'b1, 2'd2, 6'h2B, 1'b0});
    run_update(0, 0, 1'b0, dn, bn);
    check("lat_done", 32'(dn), 32'd29);
    check("lat_busy", 32'(bn), 32'd28);
    check("snap_final", 32'(snap_now()), {22'd0, 1'b1, 2'd2, 6'h2B, 1'b0});
    check("rf_lock", 32'(rf[22]), 32'd0);
    check("rf_sprite5", 32'(rf[5]), 32'h0105);
    check("rf_sprite21", 32'(rf[21]), 32'h0115);

    // Scenario 4: five-cycle source stall at idx 10
    status[0] = 16'h0000; status[1] = 16'h0001; status[2] = 16'hFFC5; status[3] = 16'h0003;
    push_update({1'b0, 2'd1, 6'h05, 1'b1});
    run_update(10, 5, 1'b0, dn, bn);
    check("stall_lat_done", 32'(dn), 32'd34);
    check("stall_lat_busy", 32'(bn), 32'd33);

    // Scenario 5: starts while busy and in DONE are dropped
    status[0] = 16'h0001; status[1] = 16'h0003; status[2] = 16'h0010; status[3] = 16'h0000;
    push_update({1'b1, 2'd3, 6'h10, 1'b0});
    run_update(0, 0, 1'b1, dn, bn);
    check("drop_done", 32'(dn), 32'd29);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("drop_idle", {30'd0, busy, done}, 32'd0);
    end
    push_update({1'b1, 2'd3, 6'h10, 1'b0});
    run_update(0, 0, 1'b0, dn, bn);
    check("fresh_done", 32'(dn), 32'd29);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size() + snap_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
